// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU codes, RV32I major opcodes, FSM states and decode-field types
// for the operand stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_ISSUE} stage_state_e;
  typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_U}     imm_sel_e;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO}        a_sel_e;
  typedef enum logic [1:0] {SH_NONE, SH_RS2, SH_IMM}    shamt_src_e;

  typedef struct packed {
    alu_op_e    opcode;
    imm_sel_e   imm_sel;
    a_sel_e     a_sel;
    shamt_src_e shamt_src;
    logic       illegal;
  } dec_t;

  // alt selects SUB/SRA; callers pass 0 where the alternate form does not exist
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Upstream instr/pc handshake, regfile read port and downstream ALU operand bus.
interface alu_operand_stage_if #(
  parameter int XLEN  = 32,
  parameter int OPC_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  instr;
  logic [XLEN-1:0]  pc;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  operand_A;
  logic [XLEN-1:0]  operand_B;
  logic [OPC_W-1:0] opcode;
  logic [4:0]       shift_amount;
  logic [4:0]       rd;
  logic             illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid,
           operand_A, operand_B, opcode, shift_amount, rd, illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid,
           operand_A, operand_B, opcode, shift_amount, rd, illegal
  );
endinterface

// File: rtl/alu_operand_stage_decode.sv
// Combinational RV32I decode of OP / OP-IMM / LUI / AUIPC into ALU opcode
// and operand-select fields.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [6:0] major;
  logic [2:0] f3;
  logic [6:0] f7;

  assign major = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  always_comb begin
    dec = '{opcode: ALU_ADD, imm_sel: IMM_NONE, a_sel: A_RS1,
            shamt_src: SH_NONE, illegal: 1'b0};
    case (major)
      OPC_OP: begin
        dec.opcode  = f3_to_op(f3, f7[5]);
        dec.illegal = !(f7 == 7'h00 || f7 == 7'h20);
        if (f3 == 3'b001 || f3 == 3'b101) dec.shamt_src = SH_RS2;
      end
      OPC_OP_IMM: begin
        dec.imm_sel = IMM_I;
        // funct7 only carries meaning for the shift-immediate forms
        dec.opcode  = f3_to_op(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001) begin
          dec.shamt_src = SH_IMM;
          dec.illegal   = (f7 != 7'h00);
        end else if (f3 == 3'b101) begin
          dec.shamt_src = SH_IMM;
          dec.illegal   = (f7 != 7'h00) && (f7 != 7'h20);
        end
      end
      OPC_LUI: begin
        dec.imm_sel = IMM_U;
        dec.a_sel   = A_ZERO;
      end
      OPC_AUIPC: begin
        dec.imm_sel = IMM_U;
        dec.a_sel   = A_PC;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.opcode    = ALU_ADD;
      dec.imm_sel   = IMM_NONE;
      dec.a_sel     = A_ZERO;
      dec.shamt_src = SH_NONE;
    end
  end
endmodule

// File: rtl/alu_operand_stage.sv
// Decode/operand stage feeding Execution_Unit: IDLE -> READ -> ISSUE, one instr in flight.
// Optional write-back forwarding in READ when ALU_OPSTAGE_FWD_EN is defined.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OPC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
`ifdef ALU_OPSTAGE_FWD_EN
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  alu_operand_stage_if.slave bus
);
  stage_state_e     state_q, state_d;
  logic [XLEN-1:0]  instr_q, pc_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [OPC_W-1:0] opc_q;
  logic [4:0]       shamt_q, rd_q;
  logic             ill_q;

  dec_t             dec;
  logic             accept, load;
  logic [4:0]       rs1_a, rs2_a;
  logic [XLEN-1:0]  rs1_v, rs2_v, imm_i, imm_u, a_nxt, b_nxt;
  logic [4:0]       sh_nxt;

  alu_op_decode u_dec (.instr(instr_q), .dec(dec));

  assign rs1_a = instr_q[19:15];
  assign rs2_a = instr_q[24:20];
  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_u = {instr_q[31:12], 12'b0};

  // flush blocks capture in IDLE and the output load in READ
  assign accept = (state_q == ST_IDLE) && bus.in_valid && !flush;
  assign load   = (state_q == ST_READ) && !flush;

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = ST_READ;
      end
      ST_READ: state_d = ST_ISSUE;
      ST_ISSUE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // x0 reads as zero regardless of what the regfile returns
  always_comb begin
    rs1_v = (rs1_a == 5'd0) ? '0 : bus.rs1_data;
    rs2_v = (rs2_a == 5'd0) ? '0 : bus.rs2_data;
`ifdef ALU_OPSTAGE_FWD_EN
    if (wb_valid && rs1_a != 5'd0 && wb_rd == rs1_a) rs1_v = wb_data;
    if (wb_valid && rs2_a != 5'd0 && wb_rd == rs2_a) rs2_v = wb_data;
`endif
  end

  always_comb begin
    case (dec.a_sel)
      A_PC:    a_nxt = pc_q;
      A_ZERO:  a_nxt = '0;
      default: a_nxt = rs1_v;
    endcase
    case (dec.imm_sel)
      IMM_I:   b_nxt = imm_i;
      IMM_U:   b_nxt = imm_u;
      default: b_nxt = rs2_v;
    endcase
    case (dec.shamt_src)
      SH_RS2:  sh_nxt = rs2_v[4:0];
      SH_IMM:  sh_nxt = instr_q[24:20];
      default: sh_nxt = 5'd0;
    endcase
    if (dec.illegal) begin
      a_nxt = '0;
      b_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= '0;
      shamt_q <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= bus.instr;
        pc_q    <= bus.pc;
      end
      if (load) begin
        a_q     <= a_nxt;
        b_q     <= b_nxt;
        opc_q   <= OPC_W'(dec.opcode);
        shamt_q <= sh_nxt;
        rd_q    <= dec.illegal ? 5'd0 : instr_q[11:7];
        ill_q   <= dec.illegal;
      end
    end
  end

  assign bus.rs1_addr     = rs1_a;
  assign bus.rs2_addr     = rs2_a;
  assign bus.operand_A    = a_q;
  assign bus.operand_B    = b_q;
  assign bus.opcode       = opc_q;
  assign bus.shift_amount = shamt_q;
  assign bus.rd           = rd_q;
  assign bus.illegal      = ill_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; regfile modelled as a combinational array
// sampled by the DUT at the end of READ.
module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic rst;
  logic flush;
`ifdef ALU_OPSTAGE_FWD_EN
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`endif
  logic [31:0] regs [32];
  int n_vec = 0;
  int n_err = 0;
  int lat;
  logic seen;

  always #5 clk = ~clk;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
`ifdef ALU_OPSTAGE_FWD_EN
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
`endif
    .bus   (bus)
  );

  assign bus.rs1_data = regs[bus.rs1_addr];
  assign bus.rs2_data = regs[bus.rs2_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // called at a negedge with the DUT idle; returns at the negedge inside READ
  task automatic accept(input logic [31:0] w, input logic [31:0] p);
    bus.instr    = w;
    bus.pc       = p;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.out_ready = 1'b1;
`ifdef ALU_OPSTAGE_FWD_EN
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
`endif
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[0] = 32'h0000_DEAD;  // misbehaving x0 must be masked by the DUT
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    regs[6] = 32'h8000_0000;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_A",         bus.operand_A, 0);
    chk("rst_B",         bus.operand_B, 0);
    chk("rst_opcode",    bus.opcode,    0);
    chk("rst_rs1_addr",  bus.rs1_addr,  0);

    // ADD x3,x1,x2
    accept(32'h0020_81B3, 32'h0);
    chk("add_read_in_ready", bus.in_ready, 0);
    chk("add_rs1_addr", bus.rs1_addr, 1);
    chk("add_rs2_addr", bus.rs2_addr, 2);
    wait_valid(lat);
    chk("add_latency", lat, 1);
    chk("add_A",      bus.operand_A, 5);
    chk("add_B",      bus.operand_B, 7);
    chk("add_opcode", bus.opcode, 0);
    chk("add_rd",     bus.rd, 3);
    chk("add_shamt",  bus.shift_amount, 0);
    chk("add_illegal", bus.illegal, 0);
    @(negedge clk);
    chk("add_next_in_ready", bus.in_ready, 1);
    chk("add_next_out_valid", bus.out_valid, 0);

    // SRAI x5,x6,3
    accept(32'h4033_5293, 32'h0);
    wait_valid(lat);
    chk("srai_latency", lat, 1);
    chk("srai_A",      bus.operand_A, 32'h8000_0000);
    chk("srai_B",      bus.operand_B, 32'h0000_0403);
    chk("srai_opcode", bus.opcode, 7);
    chk("srai_shamt",  bus.shift_amount, 3);
    chk("srai_rd",     bus.rd, 5);
    chk("srai_illegal", bus.illegal, 0);
    @(negedge clk);

    // SLL x4,x1,x2 : shamt from rs2 data
    accept(32'h0020_9233, 32'h0);
    wait_valid(lat);
    chk("sll_opcode", bus.opcode, 2);
    chk("sll_shamt",  bus.shift_amount, 7);
    chk("sll_B",      bus.operand_B, 7);
    @(negedge clk);

    // AUIPC x1,0x12345 at pc 0x100
    accept(32'h1234_5097, 32'h100);
    wait_valid(lat);
    chk("auipc_A",      bus.operand_A, 32'h100);
    chk("auipc_B",      bus.operand_B, 32'h1234_5000);
    chk("auipc_opcode", bus.opcode, 0);
    chk("auipc_rd",     bus.rd, 1);
    @(negedge clk);

    // ADD x1,x0,x2 with x0 returning 0xDEAD
    accept(32'h0020_00B3, 32'h0);
    wait_valid(lat);
    chk("x0_A", bus.operand_A, 0);
    chk("x0_B", bus.operand_B, 7);
    @(negedge clk);

    // stall 5 cycles in ISSUE
    bus.out_ready = 1'b0;
    accept(32'h0020_81B3, 32'h0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_A",         bus.operand_A, 5);
      chk("stall_in_ready",  bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", bus.in_ready, 1);

    // flush during READ
    accept(32'h0020_81B3, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_read_in_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_read_no_valid", seen, 0);

    // flush in IDLE with in_valid high: nothing captured
    bus.instr = 32'h0020_81B3; bus.in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_in_ready", bus.in_ready, 1);

    // flush in ISSUE
    bus.out_ready = 1'b0;
    accept(32'h0020_81B3, 32'h0);
    wait_valid(lat);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_issue_out_valid", bus.out_valid, 0);
    chk("flush_issue_in_ready",  bus.in_ready, 1);

    // unknown major opcode
    accept(32'h0000_007F, 32'h0);
    wait_valid(lat);
    chk("ill_latency", lat, 1);
    chk("ill_flag",   bus.illegal, 1);
    chk("ill_A",      bus.operand_A, 0);
    chk("ill_B",      bus.operand_B, 0);
    chk("ill_opcode", bus.opcode, 0);
    chk("ill_rd",     bus.rd, 0);
    @(negedge clk);

    // OP with funct7=0x01 (MUL) is not handled here
    accept(32'h0220_81B3, 32'h0);
    wait_valid(lat);
    chk("mul_illegal", bus.illegal, 1);
    chk("mul_A",       bus.operand_A, 0);
    @(negedge clk);

    // SLLI with funct7=0x20
    accept(32'h4020_9213, 32'h0);
    wait_valid(lat);
    chk("slli_bad_illegal", bus.illegal, 1);
    chk("slli_bad_shamt",   bus.shift_amount, 0);
    @(negedge clk);

`ifdef ALU_OPSTAGE_FWD_EN
    accept(32'h0020_81B3, 32'h0);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    wait_valid(lat);
    wb_valid = 1'b0;
    chk("fwd_A", bus.operand_A, 32'h55);
    chk("fwd_B", bus.operand_B, 7);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
